tile_plotter: RTL and testbench
===============================

Name: tile_plotter

Overview:
- Drawing stage directly downstream of the letter-display / FSM / round logic; sits directly upstream of the VGA adapter.
- Converts game state (shown letter code, win, lose, round) into a pixel stream `x`, `y`, `colour`, `plot` for the 320x240 frame buffer.
- Draws six letter tiles (A–F) in one row. Repaints the whole row, one pixel per clock, whenever the game state changes.

Parameters:
- TILE_W, 40, tile width in pixels
- TILE_H, 40, tile height in pixels
- X0, 20, x of tile 0 left edge
- Y0, 100, y of top edge of all tiles
- GAP, 10, horizontal gap between tiles
- Legality constraint: X0 + 6*TILE_W + 5*GAP <= 320 and Y0 + TILE_H <= 240; elaboration error otherwise.

Ports:
- clk  in  1  system clock (CLOCK_50)
- rst  in  1  asynchronous active-high reset
- disp  in  4  currently shown letter code; 4'hA..4'hF = A..F; any other value = no highlight
- win  in  1  round-won flag from FSM
- lose  in  1  wrong-guess flag from FSM
- round  in  3  current round number
- x  out  9  pixel column to adapter
- y  out  8  pixel row to adapter
- colour  out  3  RGB pixel colour to adapter
- plot  out  1  write strobe; pixel written on every clk with plot=1
- busy  out  1  high while a repaint is in progress

Behaviour:
- **Reset** (async, immediate): state=IDLE; x=0, y=0, colour=0, plot=0, busy=0; snapshot-valid flag cleared.
- **Snapshot**: registered copy of {disp, win, lose, round} taken at start of each repaint.
  - In IDLE, a repaint is requested if the snapshot-valid flag is 0 or live inputs differ from the snapshot.
  - Consequence: one automatic repaint after reset.
- **FSM**: IDLE -> LOAD -> DRAW -> IDLE.
  - IDLE: plot=0, busy=0. Request seen on cycle N -> LOAD on N+1.
  - LOAD (1 cycle): latch snapshot, set valid=1; tile=0, px=0, py=0, tile_base=X0; busy=1, plot=0.
  - DRAW: plot=1 every cycle; first pixel on cycle N+2.
    - x = tile_base + px, y = Y0 + py.
    - px runs 0..TILE_W-1, then wraps with py+1. py wraps after TILE_H-1, then tile+1 and tile_base += TILE_W+GAP. No multiplier.
    - After pixel (TILE_W-1, TILE_H-1) of tile 5 -> IDLE; plot=0 and busy=0 on the next cycle.
  - Repaint length: exactly 6*TILE_W*TILE_H cycles of plot=1 (9600 at defaults), contiguous.
- **Colour** (from snapshot, never live inputs), priority order:
  1. lose=1 -> 3'b100 red, all tiles
  2. win=1 -> 3'b010 green, all tiles
  3. round==0 -> 3'b111 white, all tiles
  4. tile index == disp-4'hA with disp in A..F -> 3'b110 yellow
  5. otherwise -> 3'b001 blue
- **Input changes during DRAW**: ignored. On return to IDLE the compare runs again, so the final stable state is always painted; no partial-frame mixing.
- **rst mid-DRAW**: plot drops immediately. After release, a full repaint restarts from tile 0.
- **Outputs**: x, y, colour, plot are all registered; no combinational path from inputs to outputs.
- **Widths**: px and py are sized by $clog2 of their parameter; tile index is 3 bits; tile_base is 9 bits; x and y never exceed 319/239 by the legality constraint.

Decomposition:
- Shared package `memgame_pkg`:
  - colour constants COL_RED, COL_GREEN, COL_WHITE, COL_YELLOW, COL_BLUE, COL_BLACK
  - LETTER_BASE = 4'hA
  - NUM_TILES = 6
  - FSM state typedef {IDLE, LOAD, DRAW}
- Sub-module `rect_scanner`:
  - Generic px/py counter for one W x H rectangle.
  - Inputs: start, advance. Outputs: px, py, last.
  - Instantiated once; tile stepping stays in tile_plotter.

Test Plan:
- **Reset, then disp=0, win=0, lose=0, round=1 held** -> first plot at (20,100), colour 3'b001. Exactly 9600 plot cycles. Last pixel (309,139). busy falls the cycle after. No further plot while inputs are stable.
- **disp=4'hC, round=2 after idle** -> repaint. Pixels x 120..159, y 100..139 are 3'b110; all other tiles 3'b001.
- **lose pulsed to 1 at cycle 3000 of a repaint and held** -> current repaint finishes with old colours. A second 9600-cycle repaint follows, all 3'b100.
- **win=1 and lose=1 simultaneously** -> all pixels 3'b100 (lose priority).
- **rst asserted at cycle 5000 of DRAW** -> plot=0 and busy=0 in the same cycle. After release, repaint restarts at (20,100).
- **round=0, disp=4'hA** -> all tiles 3'b111, no yellow highlight.

Source files
------------

// File: rtl/memgame_pkg.sv
// rtl/memgame_pkg.sv - shared colours, letter codes, FSM states and snapshot type for the memory game
package memgame_pkg;

   localparam logic [2:0] COL_RED    = 3'b100;
   localparam logic [2:0] COL_GREEN  = 3'b010;
   localparam logic [2:0] COL_WHITE  = 3'b111;
   localparam logic [2:0] COL_YELLOW = 3'b110;
   localparam logic [2:0] COL_BLUE   = 3'b001;
   localparam logic [2:0] COL_BLACK  = 3'b000;

   localparam logic [3:0] LETTER_BASE = 4'hA;
   localparam int         NUM_TILES   = 6;

   typedef enum logic [1:0] {IDLE, LOAD, DRAW} state_t;

   typedef struct packed {
      logic [3:0] disp;
      logic       win;
      logic       lose;
      logic [2:0] round;
   } snap_t;

   // Lose beats win beats the round-0 splash; only then is a single letter highlighted.
   function automatic logic [2:0] tile_colour(snap_t s, logic [2:0] tile);
      if (s.lose)
         return COL_RED;
      else if (s.win)
         return COL_GREEN;
      else if (s.round == 3'd0)
         return COL_WHITE;
      else if (s.disp >= LETTER_BASE && (s.disp - LETTER_BASE) == {1'b0, tile})
         return COL_YELLOW;
      return COL_BLUE;
   endfunction

endpackage

// File: rtl/rect_scanner.sv
// rtl/rect_scanner.sv - raster px/py counter over one W x H rectangle
module rect_scanner #(
   parameter int W = 40,
   parameter int H = 40,
   localparam int XW = (W > 1) ? $clog2(W) : 1,
   localparam int YW = (H > 1) ? $clog2(H) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          advance,
   output logic [XW-1:0] px,
   output logic [YW-1:0] py,
   output logic          last
);

   localparam logic [XW-1:0] PX_LAST = XW'(W - 1);
   localparam logic [YW-1:0] PY_LAST = YW'(H - 1);

   assign last = (px == PX_LAST) && (py == PY_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         px <= '0;
         py <= '0;
      end else if (start) begin
         px <= '0;
         py <= '0;
      end else if (advance) begin
         if (px == PX_LAST) begin
            px <= '0;
            py <= (py == PY_LAST) ? '0 : py + 1'b1;
         end else begin
            px <= px + 1'b1;
         end
      end
   end

endmodule

// File: rtl/tile_plotter.sv
// rtl/tile_plotter.sv - repaints the six letter tiles into the 320x240 frame buffer on any game-state change
module tile_plotter
   import memgame_pkg::*;
#(
   parameter int TILE_W = 40,
   parameter int TILE_H = 40,
   parameter int X0     = 20,
   parameter int Y0     = 100,
   parameter int GAP    = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] disp,
   input  logic       win,
   input  logic       lose,
   input  logic [2:0] round,
   output logic [8:0] x,
   output logic [7:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy
);

   localparam int XW = (TILE_W > 1) ? $clog2(TILE_W) : 1;
   localparam int YW = (TILE_H > 1) ? $clog2(TILE_H) : 1;

   localparam logic [8:0]    X0_L      = 9'(X0);
   localparam logic [7:0]    Y0_L      = 8'(Y0);
   localparam logic [8:0]    STEP      = 9'(TILE_W + GAP);
   localparam logic [2:0]    LAST_TILE = 3'(NUM_TILES - 1);
   localparam logic [XW-1:0] PX_LAST   = XW'(TILE_W - 1);

   if (X0 + NUM_TILES * TILE_W + (NUM_TILES - 1) * GAP > 320 || Y0 + TILE_H > 240) begin : g_illegal
      $error("tile_plotter: tile row does not fit the 320x240 frame");
   end

   state_t        state;
   snap_t         snap;
   snap_t         live;
   logic          snap_valid;
   logic [2:0]    tile;
   logic [8:0]    tile_base;
   logic [XW-1:0] px;
   logic [YW-1:0] py;
   logic          last;
   logic          request;

   assign live    = {disp, win, lose, round};
   assign request = !snap_valid || (live != snap);

   // Scanner counters always describe the pixel currently on x/y.
   rect_scanner #(.W(TILE_W), .H(TILE_H)) u_scan (
      .clk     (clk),
      .rst     (rst),
      .start   (state == LOAD),
      .advance (state == DRAW),
      .px      (px),
      .py      (py),
      .last    (last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         snap       <= '0;
         snap_valid <= 1'b0;
         tile       <= '0;
         tile_base  <= '0;
         x          <= '0;
         y          <= '0;
         colour     <= COL_BLACK;
         plot       <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               plot <= 1'b0;
               if (request) begin
                  state <= LOAD;
                  busy  <= 1'b1;
               end else begin
                  busy  <= 1'b0;
               end
            end
            LOAD: begin
               // The snapshot is being captured from live on this edge, so tile 0 uses the same value.
               snap       <= live;
               snap_valid <= 1'b1;
               tile       <= '0;
               tile_base  <= X0_L;
               x          <= X0_L;
               y          <= Y0_L;
               colour     <= tile_colour(live, 3'd0);
               plot       <= 1'b1;
               busy       <= 1'b1;
               state      <= DRAW;
            end
            DRAW: begin
               if (last) begin
                  if (tile == LAST_TILE) begin
                     state <= IDLE;
                     plot  <= 1'b0;
                     busy  <= 1'b0;
                  end else begin
                     tile      <= tile + 3'd1;
                     tile_base <= tile_base + STEP;
                     x         <= tile_base + STEP;
                     y         <= Y0_L;
                     colour    <= tile_colour(snap, tile + 3'd1);
                  end
               end else if (px == PX_LAST) begin
                  x <= tile_base;
                  y <= Y0_L + 8'(py) + 8'd1;
               end else begin
                  x <= x + 9'd1;
               end
            end
            default: begin
               state <= IDLE;
               plot  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tile_plotter.sv
// tb/tb_tile_plotter.sv - scoreboard bench for tile_plotter repaint sequences
module tb_tile_plotter;

   logic       clk;
   logic       rst;
   logic [3:0] disp;
   logic       win;
   logic       lose;
   logic [2:0] round;
   logic [8:0] x;
   logic [7:0] y;
   logic [2:0] colour;
   logic       plot;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   logic [19:0] exp_q[$];

   tile_plotter dut (
      .clk    (clk),
      .rst    (rst),
      .disp   (disp),
      .win    (win),
      .lose   (lose),
      .round  (round),
      .x      (x),
      .y      (y),
      .colour (colour),
      .plot   (plot),
      .busy   (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [2:0] exp_col(logic [3:0] d, logic w, logic l, logic [2:0] r, int t);
      if (l) return 3'b100;
      if (w) return 3'b010;
      if (r == 3'd0) return 3'b111;
      if (d >= 4'hA && (int'(d) - 10) == t) return 3'b110;
      return 3'b001;
   endfunction

   task automatic check(input string tag, input int obs, input int exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   // Pushes the full expected frame, then pops one entry per plotted pixel.
   task automatic paint_check(input string tag, input logic [3:0] d, input logic w, input logic l,
                              input logic [2:0] r, input int lose_at, input int abort_at);
      int          waitc;
      int          n;
      int          bad;
      logic [19:0] e;
      waitc = 0;
      n     = 0;
      bad   = 0;
      exp_q.delete();
      for (int t = 0; t < 6; t++)
         for (int yy = 0; yy < 40; yy++)
            for (int xx = 0; xx < 40; xx++)
               exp_q.push_back({9'(20 + t * 50 + xx), 8'(100 + yy), exp_col(d, w, l, r, t)});
      while (plot !== 1'b1 && waitc < 8) begin
         @(negedge clk);
         waitc++;
      end
      check({tag, "_start"}, int'(plot), 1);
      check({tag, "_first_x"}, int'(x), 20);
      check({tag, "_first_y"}, int'(y), 100);
      while (exp_q.size() > 0 && plot === 1'b1) begin
         if (n == abort_at) begin
            rst = 1'b1;
            #1;
            check({tag, "_rst_plot"}, int'(plot), 0);
            check({tag, "_rst_busy"}, int'(busy), 0);
            exp_q.delete();
            return;
         end
         if (n == lose_at) lose = 1'b1;
         e = exp_q.pop_front();
         if ({x, y, colour} !== e) begin
            if (bad < 3)
               $info("%s pixel %0d got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
                     tag, n, x, y, colour, e[19:11], e[10:3], e[2:0]);
            bad++;
         end
         n++;
         @(negedge clk);
      end
      check({tag, "_plot_count"}, n, 9600);
      check({tag, "_bad_pixels"}, bad, 0);
      check({tag, "_end_plot"}, int'(plot), 0);
      check({tag, "_end_busy"}, int'(busy), 0);
      exp_q.delete();
   endtask

   initial begin
      int plots;
      rst   = 1'b1;
      disp  = 4'h0;
      win   = 1'b0;
      lose  = 1'b0;
      round = 3'd1;
      repeat (3) @(negedge clk);
      check("rst_plot", int'(plot), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_x", int'(x), 0);
      check("rst_y", int'(y), 0);
      check("rst_colour", int'(colour), 0);

      rst = 1'b0;
      @(negedge clk);
      check("load_busy", int'(busy), 1);
      check("load_plot", int'(plot), 0);
      paint_check("boot", 4'h0, 1'b0, 1'b0, 3'd1, -1, -1);

      plots = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (plot === 1'b1 || busy === 1'b1) plots++;
      end
      check("idle_quiet", plots, 0);

      disp  = 4'hC;
      round = 3'd2;
      paint_check("hilite_c", 4'hC, 1'b0, 1'b0, 3'd2, -1, -1);

      disp = 4'hE;
      paint_check("lose_old", 4'hE, 1'b0, 1'b0, 3'd2, 3000, -1);
      paint_check("lose_new", 4'hE, 1'b0, 1'b1, 3'd2, -1, -1);

      win = 1'b1;
      paint_check("win_lose", 4'hE, 1'b1, 1'b1, 3'd2, -1, -1);

      win   = 1'b0;
      lose  = 1'b0;
      disp  = 4'hB;
      round = 3'd3;
      paint_check("rst_mid", 4'hB, 1'b0, 1'b0, 3'd3, -1, 5000);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      paint_check("after_rst", 4'hB, 1'b0, 1'b0, 3'd3, -1, -1);

      disp  = 4'hA;
      round = 3'd0;
      paint_check("round0", 4'hA, 1'b0, 1'b0, 3'd0, -1, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
